// File: rtl/cpu_types_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_types_pkg - shared CPU-side types: RAM handshake state, arbiter state  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Prefixed so the names do not collide with ramstate_t::BUSY.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
// +----------------------------------------------------------------------------+
// | rr_picker - round-robin selector: first requester after the last index     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         valid
);

  logic [W-1:0] w_idx;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = W'((int'(last) + k) % N);
      if (req[w_idx]) begin
        grant = w_idx;
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter - shares one RAM port between CPUS cores (I and D per core)    |
// | Optional LL/SC link tracking compiled in with macro ATOMIC_LINK_EN.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int DFIRST = 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] iREN,
  input  logic [31:0]     iaddr   [CPUS],
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  logic [CPUS-1:0] datomic,
  input  logic [31:0]     daddr   [CPUS],
  input  logic [31:0]     dstore  [CPUS],
  output logic [CPUS-1:0] iwait,
  output logic [CPUS-1:0] dwait,
  output logic [31:0]     iload   [CPUS],
  output logic [31:0]     dload   [CPUS],
  output logic            ramREN,
  output logic            ramWEN,
  output logic [31:0]     ramaddr,
  output logic [31:0]     ramstore,
  input  logic [31:0]     ramload,
  input  ramstate_t       ramstate
);

  localparam int IW = idx_w(CPUS);

  arb_state_t      r_state;
  logic [IW-1:0]   r_owner;
  logic            r_owner_d;
  logic [IW-1:0]   r_last;

  logic [CPUS-1:0] w_dreq, w_req;
  logic [IW-1:0]   w_pick;
  logic            w_pick_valid, w_pick_d;
  logic            w_busy, w_own_req, w_own_wr, w_live, w_act, w_done, w_sc_fail;
  logic [31:0]     w_own_addr, w_dval;

  assign w_dreq = dREN | dWEN;
  assign w_req  = iREN | w_dreq;

  rr_picker #(.N(CPUS), .W(IW)) u_rr (
    .req   (w_req),
    .last  (r_last),
    .grant (w_pick),
    .valid (w_pick_valid)
  );

  assign w_pick_d   = (DFIRST != 0) ? w_dreq[w_pick] : ~iREN[w_pick];
  assign w_busy     = (r_state == ARB_BUSY);
  assign w_own_req  = r_owner_d ? w_dreq[r_owner] : iREN[r_owner];
  assign w_own_wr   = r_owner_d & dWEN[r_owner];
  assign w_own_addr = r_owner_d ? daddr[r_owner] : iaddr[r_owner];
  assign w_live     = w_busy & w_own_req;
  assign w_act      = w_live & ~w_sc_fail;
  assign w_done     = w_live & ((ramstate == ACCESS) | w_sc_fail);

  assign ramREN   = w_act & ~w_own_wr;
  assign ramWEN   = w_act & w_own_wr;
  assign ramaddr  = w_act ? w_own_addr : '0;
  assign ramstore = (w_act & w_own_wr) ? dstore[r_owner] : '0;

`ifdef ATOMIC_LINK_EN
  logic            w_link_v [CPUS];
  logic [31:0]     w_link_a [CPUS];
  logic            w_is_sc, w_wr_done, w_ll_done;

  assign w_is_sc   = w_own_wr & datomic[r_owner];
  // A failing SC completes in its grant cycle without touching RAM.
  assign w_sc_fail = w_live & w_is_sc &
                     ~(w_link_v[r_owner] & (w_link_a[r_owner] == daddr[r_owner]));
  assign w_wr_done = w_act & w_own_wr & (ramstate == ACCESS);
  assign w_ll_done = w_act & r_owner_d & ~dWEN[r_owner] & datomic[r_owner] &
                     (ramstate == ACCESS);
  assign w_dval    = w_is_sc ? {31'd0, ~w_sc_fail} : ramload;

  for (genvar c = 0; c < CPUS; c++) begin : g_link
    logic        r_v;
    logic [31:0] r_a;
    assign w_link_v[c] = r_v;
    assign w_link_a[c] = r_a;
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_v <= 1'b0;
        r_a <= '0;
      end else if (w_ll_done && (r_owner == IW'(c))) begin
        r_v <= 1'b1;
        r_a <= daddr[r_owner];
      end else if (w_wr_done && (r_a == daddr[r_owner])) begin
        r_v <= 1'b0;
      end
    end
  end
`else
  logic w_unused_atomic;
  assign w_unused_atomic = ^datomic;
  assign w_sc_fail       = 1'b0;
  assign w_dval          = ramload;
`endif

  for (genvar c = 0; c < CPUS; c++) begin : g_core
    logic w_own, w_hit_i, w_hit_d;
    assign w_own    = (r_owner == IW'(c));
    assign w_hit_i  = w_done & w_own & ~r_owner_d;
    assign w_hit_d  = w_done & w_own & r_owner_d;
    assign iwait[c] = iREN[c] & ~w_hit_i;
    assign dwait[c] = w_dreq[c] & ~w_hit_d;
    assign iload[c] = w_hit_i ? ramload : '0;
    assign dload[c] = w_hit_d ? w_dval : '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ARB_IDLE;
      r_owner   <= '0;
      r_owner_d <= 1'b0;
      r_last    <= IW'(CPUS - 1);
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_state   <= ARB_BUSY;
            r_owner   <= w_pick;
            r_owner_d <= w_pick_d;
          end
        end
        ARB_BUSY: begin
          if (w_done) begin
            r_state <= ARB_IDLE;
            r_last  <= r_owner;
          end else if (!w_own_req) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter - directed and randomized checks of mem_arbiter             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int N = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [N-1:0]  iREN, dREN, dWEN, datomic;
  logic [31:0]   iaddr [N], daddr [N], dstore [N];
  logic [N-1:0]  iwait, dwait, a_iwait, a_dwait;
  logic [31:0]   iload [N], dload [N], a_iload [N], a_dload [N];
  logic          ramREN, ramWEN, a_ramREN, a_ramWEN;
  logic [31:0]   ramaddr, ramstore, a_ramaddr, a_ramstore, ramload;
  ramstate_t     ramstate;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.CPUS(N), .DFIRST(1)) u_dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .datomic(datomic), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  mem_arbiter #(.CPUS(N), .DFIRST(0)) u_alt (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .datomic(datomic), .daddr(daddr), .dstore(dstore), .iwait(a_iwait), .dwait(a_dwait),
    .iload(a_iload), .dload(a_dload), .ramREN(a_ramREN), .ramWEN(a_ramWEN),
    .ramaddr(a_ramaddr), .ramstore(a_ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; datomic = '0;
    for (int i = 0; i < N; i++) begin
      iaddr[i] = '0; daddr[i] = '0; dstore[i] = '0;
    end
    ramload  = '0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic wait_active(output int polls);
    polls = 0;
    #1;
    while (!(ramREN | ramWEN) && polls < 20) begin
      polls++;
      @(posedge CLK); #2;
    end
    check("grant_seen", 32'(ramREN | ramWEN), 32'd1);
  endtask

  // Acts as the RAM for one transaction; returns at the negedge of its ACCESS cycle.
  task automatic run_txn(input int lat, input logic [31:0] load, output logic [31:0] addr,
                         output logic [31:0] aaddr, output logic wen, output int polls);
    wait_active(polls);
    addr  = ramaddr;
    aaddr = a_ramaddr;
    wen   = ramWEN;
    repeat (lat) begin
      ramstate = BUSY;
      @(posedge CLK); #2;
    end
    ramstate = ACCESS;
    ramload  = load;
    @(negedge CLK);
  endtask

  task automatic end_txn();
    @(posedge CLK); #1;
    ramstate = FREE;
  endtask

  // Random-phase model state
  logic [N-1:0] ipend, dpend, dwr, dx, prev_pi, prev_pd, served_i, served_d;
  logic [31:0]  ia [N], da [N], ds [N];
  logic         active, prev_active, prev_access, acc, exp_active, cur_d, found;
  int           cur, last, lat;

  initial begin
    logic [31:0] addr, aaddr;
    logic        wen;
    int          polls;

    // Reset state, with a request already waiting
    clear_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    iREN[0] = 1'b1; iaddr[0] = 32'h100;
    #1;
    check("rst_ramREN", 32'(ramREN), 0);
    check("rst_ramWEN", 32'(ramWEN), 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iwait0", 32'(iwait[0]), 1);
    check("rst_dwait0", 32'(dwait[0]), 0);
    nRST = 1'b1;

    // Single instruction fetch, 2-cycle RAM
    @(negedge CLK);
    check("if_idle_ramREN", 32'(ramREN), 0);
    check("if_idle_iwait", 32'(iwait[0]), 1);
    @(posedge CLK); #1; ramstate = BUSY;
    @(negedge CLK);
    check("if_busy_ramREN", 32'(ramREN), 1);
    check("if_busy_ramaddr", ramaddr, 32'h100);
    check("if_busy_iwait", 32'(iwait[0]), 1);
    check("if_busy_iload", iload[0], 0);
    @(posedge CLK); #1; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    check("if_acc_iload", iload[0], 32'hDEADBEEF);
    check("if_acc_iwait", 32'(iwait[0]), 0);
    check("if_acc_iload1", iload[1], 0);
    @(posedge CLK); #1; ramstate = FREE;
    @(negedge CLK);
    check("if_bubble_ramREN", 32'(ramREN), 0);
    check("if_bubble_iwait", 32'(iwait[0]), 1);

    // Two cores streaming data reads alternate, starting at core 0
    do_reset();
    dREN = 2'b11; daddr[0] = 32'hA0; daddr[1] = 32'hB0;
    for (int t = 0; t < 3; t++) begin
      int c;
      c = t % 2;
      run_txn(t, 32'h1000 + 32'(t), addr, aaddr, wen, polls);
      check("rr_addr", addr, (c == 0) ? 32'hA0 : 32'hB0);
      check("rr_bubble", 32'(polls), 1);
      check("rr_dload", dload[c], 32'h1000 + 32'(t));
      check("rr_dwait_other", 32'(dwait[1-c]), 1);
      end_txn();
    end

    // D vs I priority within one core
    do_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h300; iREN[0] = 1'b1; iaddr[0] = 32'h400;
    run_txn(1, 32'h3333, addr, aaddr, wen, polls);
    check("pri_d_first", addr, 32'h300);
    check("pri_i_first_alt", aaddr, 32'h400);
    check("pri_dload", dload[0], 32'h3333);
    check("pri_iwait_held", 32'(iwait[0]), 1);
    check("pri_alt_iload", a_iload[0], 32'h3333);
    end_txn();
    dREN[0] = 1'b0;
    run_txn(0, 32'h4444, addr, aaddr, wen, polls);
    check("pri_i_second", addr, 32'h400);
    check("pri_i_bubble", 32'(polls), 1);
    check("pri_iload", iload[0], 32'h4444);
    end_txn();

    // Reset pulse in the middle of a write
    do_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h600;
    run_txn(0, 32'h6, addr, aaddr, wen, polls);
    end_txn();
    dREN[0] = 1'b0;
    dWEN[1] = 1'b1; daddr[1] = 32'h500; dstore[1] = 32'h55;
    wait_active(polls);
    check("rp_wen_before", 32'(ramWEN), 1);
    check("rp_store_before", ramstore, 32'h55);
    dREN[0] = 1'b1;
    ramstate = BUSY;
    #1 nRST = 1'b0;
    #1;
    check("rp_wen_during", 32'(ramWEN), 0);
    check("rp_addr_during", ramaddr, 0);
    check("rp_store_during", ramstore, 0);
    check("rp_dwait1_during", 32'(dwait[1]), 1);
    @(posedge CLK); #1 nRST = 1'b1;
    run_txn(0, 32'h66, addr, aaddr, wen, polls);
    check("rp_first_after", addr, 32'h600);
    end_txn();
    dREN[0] = 1'b0;
    run_txn(0, 32'h0, addr, aaddr, wen, polls);
    check("rp_retry_addr", addr, 32'h500);
    check("rp_retry_wen", 32'(wen), 1);
    end_txn();
    dWEN[1] = 1'b0;

`ifdef ATOMIC_LINK_EN
    // LL / SC with and without an intervening store from the other core
    do_reset();
    dREN[0] = 1'b1; datomic[0] = 1'b1; daddr[0] = 32'h200;
    run_txn(0, 32'h77, addr, aaddr, wen, polls);
    end_txn();
    dREN[0] = 1'b0; datomic[0] = 1'b0;
    dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'h7;
    run_txn(0, 32'h0, addr, aaddr, wen, polls);
    end_txn();
    dWEN[1] = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      dWEN[0] = 1'b1; datomic[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'h99;
      @(negedge CLK);
      check("sc_fail_idle_dwait", 32'(dwait[0]), 1);
      @(negedge CLK);
      check("sc_fail_dwait", 32'(dwait[0]), 0);
      check("sc_fail_dload", dload[0], 0);
      check("sc_fail_ramWEN", 32'(ramWEN), 0);
      @(posedge CLK); #1;
      dWEN[0] = 1'b0; datomic[0] = 1'b0;
      if (pass == 0) begin
        dREN[0] = 1'b1; datomic[0] = 1'b1;
        run_txn(0, 32'h78, addr, aaddr, wen, polls);
        end_txn();
        dREN[0] = 1'b0;
        dWEN[0] = 1'b1;
        run_txn(1, 32'hFFFF, addr, aaddr, wen, polls);
        check("sc_ok_wen", 32'(wen), 1);
        check("sc_ok_addr", addr, 32'h200);
        check("sc_ok_dload", dload[0], 32'd1);
        end_txn();
        dWEN[0] = 1'b0; datomic[0] = 1'b0;
      end
    end
`endif

    // Randomized traffic against a transaction-level model
    do_reset();
    ipend = '0; dpend = '0; dwr = '0; dx = '0; served_i = '0; served_d = '0;
    prev_pi = '0; prev_pd = '0; prev_active = 1'b0; prev_access = 1'b0;
    last = N - 1; cur = 0; cur_d = 1'b0; lat = 0;
    for (int i = 0; i < N; i++) begin
      ia[i] = '0; da[i] = '0; ds[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (served_i[c]) ipend[c] = 1'b0;
        if (served_d[c]) dpend[c] = 1'b0;
        if (!ipend[c] && $urandom_range(0, 2) == 0) begin
          ipend[c] = 1'b1;
          ia[c] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        end
        if (!dpend[c] && $urandom_range(0, 2) == 0) begin
          dpend[c] = 1'b1;
          dwr[c] = 1'($urandom_range(0, 1));
          dx[c] = 1'($urandom_range(0, 1));
          da[c] = {22'd1, 8'($urandom_range(0, 255)), 2'b00};
          ds[c] = $urandom;
        end
        iREN[c] = ipend[c]; iaddr[c] = ia[c];
        dWEN[c] = dpend[c] & dwr[c];
        dREN[c] = dpend[c] & (dwr[c] ? dx[c] : 1'b1);
        daddr[c] = da[c]; dstore[c] = ds[c];
      end
      served_i = '0; served_d = '0;
      #1;
      active = ramREN | ramWEN;
      if (active) begin
        if (!prev_active) lat = $urandom_range(0, 2);
        if (lat == 0) begin
          ramstate = ACCESS; ramload = $urandom;
        end else begin
          ramstate = ($urandom_range(0, 1) == 0) ? BUSY : ERROR;
          lat--;
        end
      end else begin
        ramstate = ramstate_t'($urandom_range(0, 3));
        ramload  = $urandom;
      end
      @(negedge CLK);
      exp_active = prev_access ? 1'b0 : (prev_active ? 1'b1 : |(prev_pi | prev_pd));
      check("rnd_active", 32'(active), 32'(exp_active));
      if (active && !prev_active) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (last + k) % N;
          if (!found && (prev_pi[c] | prev_pd[c])) begin
            found = 1'b1;
            cur   = c;
            cur_d = prev_pd[c];
          end
        end
      end
      if (active) begin
        check("rnd_ramaddr", ramaddr, cur_d ? da[cur] : ia[cur]);
        check("rnd_ramWEN", 32'(ramWEN), 32'(cur_d & dwr[cur]));
        check("rnd_ramstore", ramstore, (cur_d & dwr[cur]) ? ds[cur] : 32'd0);
      end
      acc = active && (ramstate == ACCESS);
      for (int c = 0; c < N; c++) begin
        logic hi, hd;
        hi = acc && (cur == c) && !cur_d;
        hd = acc && (cur == c) && cur_d;
        check("rnd_iwait", 32'(iwait[c]), 32'(ipend[c] & ~hi));
        check("rnd_dwait", 32'(dwait[c]), 32'(dpend[c] & ~hd));
        check("rnd_iload", iload[c], hi ? ramload : 32'd0);
        check("rnd_dload", dload[c], hd ? ramload : 32'd0);
        served_i[c] = hi;
        served_d[c] = hd;
      end
      if (acc) last = cur;
      prev_active = active; prev_access = acc; prev_pi = ipend; prev_pd = dpend;
      @(posedge CLK); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
